// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for a small MIPS-like datapath.
//
// Ports:
//   clk        - sole clock, all state changes on its rising edge
//   reset      - synchronous, active-high; returns to FETCH and clears retired
//   opcode     - 6-bit instruction opcode, sampled (and latched) only in DECODE
//   mem_ready  - memory handshake; 1 = current read/write completes this cycle
//   pc_write .. pc_src - datapath strobes and mux/ALU selects, decoded from state
//   state      - current state code
//   halt       - 1 only while trapped on an unsupported opcode
//   retired    - wrapping count of completed instructions
module mc_sequencer #(
   parameter int unsigned RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_src,
   output logic [3:0]          state,
   output logic                halt,
   output logic [RETIRE_W-1:0] retired
);

   localparam logic [3:0] StFetch   = 4'd0;
   localparam logic [3:0] StDecode  = 4'd1;
   localparam logic [3:0] StMemAddr = 4'd2;
   localparam logic [3:0] StMemRd   = 4'd3;
   localparam logic [3:0] StMemWb   = 4'd4;
   localparam logic [3:0] StMemWr   = 4'd5;
   localparam logic [3:0] StExec    = 4'd6;
   localparam logic [3:0] StRWb     = 4'd7;
   localparam logic [3:0] StBranch  = 4'd8;
   localparam logic [3:0] StJump    = 4'd9;
   localparam logic [3:0] StAddiEx  = 4'd10;
   localparam logic [3:0] StAddiWb  = 4'd11;
   localparam logic [3:0] StTrap    = 4'd12;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [RETIRE_W-1:0] RetireOne = {{(RETIRE_W-1){1'b0}}, 1'b1};

   logic [3:0]          state_q, state_d;
   logic [5:0]          opcode_q, opcode_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                retire;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      retire   = 1'b0;
      case (state_q)
         StFetch: if (mem_ready) state_d = StDecode;
         StDecode: begin
            // Latched so MEM_ADDR steers on the decoded instruction, not the live bus.
            opcode_d = opcode;
            case (opcode)
               OpRtype:    state_d = StExec;
               OpLw, OpSw: state_d = StMemAddr;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiEx;
               default:    state_d = StTrap;
            endcase
         end
         StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
         StMemRd:   if (mem_ready) state_d = StMemWb;
         StMemWr: begin
            if (mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StExec:   state_d = StRWb;
         StAddiEx: state_d = StAddiWb;
         StMemWb, StRWb, StBranch, StJump, StAddiWb: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StTrap:   state_d = StTrap;
         default:  state_d = StFetch;
      endcase
      retired_d = retire ? retired_q + RetireOne : retired_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         opcode_q  <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
      halt          = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC only capture in the cycle the instruction word arrives.
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode: alu_src_b = 2'b11;
         StMemAddr, StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StAddiWb: reg_write = 1'b1;
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
         end
         StJump: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         StTrap: halt = 1'b1;
         default: ;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed vector table, hand-written corner sequences
// (trap, retired wrap, reset during a memory wait) and randomized stimulus
// checked against an instruction-level model. A second instance with a 4-bit
// retired counter runs in lockstep to exercise counter wrap.
module tb_mc_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;

   always #5 clk = ~clk;

   logic        a_pcw, a_pwc, a_irw, a_iod, a_mrd, a_mwr, a_m2r, a_rdst, a_rw, a_asa, a_halt;
   logic [1:0]  a_asb, a_aop, a_psrc;
   logic [3:0]  a_state;
   logic [15:0] a_ret;
   logic        b_pcw, b_pwc, b_irw, b_iod, b_mrd, b_mwr, b_m2r, b_rdst, b_rw, b_asa, b_halt;
   logic [1:0]  b_asb, b_aop, b_psrc;
   logic [3:0]  b_state;
   logic [3:0]  b_ret;

   mc_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(a_pcw), .pc_write_cond(a_pwc), .ir_write(a_irw), .i_or_d(a_iod),
      .mem_read(a_mrd), .mem_write(a_mwr), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
      .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
      .pc_src(a_psrc), .state(a_state), .halt(a_halt), .retired(a_ret)
   );

   mc_sequencer #(.RETIRE_W(4)) dut4 (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(b_pcw), .pc_write_cond(b_pwc), .ir_write(b_irw), .i_or_d(b_iod),
      .mem_read(b_mrd), .mem_write(b_mwr), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
      .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
      .pc_src(b_psrc), .state(b_state), .halt(b_halt), .retired(b_ret)
   );

   logic [16:0] ctrl_a, ctrl_b;
   assign ctrl_a = {a_pcw, a_pwc, a_irw, a_iod, a_mrd, a_mwr, a_m2r, a_rdst, a_rw, a_asa,
                    a_asb, a_aop, a_psrc, a_halt};
   assign ctrl_b = {b_pcw, b_pwc, b_irw, b_iod, b_mrd, b_mwr, b_m2r, b_rdst, b_rw, b_asa,
                    b_asb, b_aop, b_psrc, b_halt};

   int vectors = 0;
   int miscompares = 0;

   // Instruction-level model: current state plus the remaining state route.
   int          m_state = 0;
   int          m_path[$];
   int unsigned m_ret = 0;

   typedef struct {
      logic [5:0] op;
      bit         mr;
      int         st;
      int         ret;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Control word expected in a given state, written from the per-state table.
   function automatic logic [16:0] exp_ctrl(input int st, input bit mr);
      logic pcw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, hlt;
      logic [1:0] asb, aop, psrc;
      {pcw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, hlt} = '0;
      {asb, aop, psrc} = '0;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         1:  asb = 2'b11;
         2, 10: begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iod = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pcw = 1; psrc = 2'b10; end
         11: rw = 1;
         12: hlt = 1;
         default: ;
      endcase
      return {pcw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, hlt};
   endfunction

   task automatic model_step(input bit rst, input logic [5:0] op, input bit mr);
      if (rst) begin
         m_state = 0;
         m_ret   = 0;
         m_path.delete();
      end else if (m_state == 0) begin
         if (mr) m_state = 1;
      end else if (m_state == 1) begin
         m_path.delete();
         case (op)
            6'b100011: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
            6'b101011: begin m_path.push_back(2); m_path.push_back(5); end
            6'b000000: begin m_path.push_back(6); m_path.push_back(7); end
            6'b000100: m_path.push_back(8);
            6'b000010: m_path.push_back(9);
            6'b001000: begin m_path.push_back(10); m_path.push_back(11); end
            default:   m_path.push_back(12);
         endcase
         m_state = m_path.pop_front();
      end else if (m_state == 12) begin
         m_state = 12;
      end else if ((m_state == 3 || m_state == 5) && !mr) begin
         m_state = m_state;
      end else if (m_path.size() == 0) begin
         m_ret++;
         m_state = 0;
      end else begin
         m_state = m_path.pop_front();
      end
   endtask

   task automatic drive(input bit rst, input logic [5:0] op, input bit mr);
      @(negedge clk);
      reset = rst;
      opcode = op;
      mem_ready = mr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(reset, opcode, mem_ready);
   endtask

   task automatic check_model();
      check("state", {28'd0, a_state}, m_state);
      check("ctrl", {15'd0, ctrl_a}, {15'd0, exp_ctrl(m_state, mem_ready)});
      check("retired", {16'd0, a_ret}, m_ret & 32'hffff);
      check("state_w4", {28'd0, b_state}, m_state);
      check("ctrl_w4", {15'd0, ctrl_b}, {15'd0, exp_ctrl(m_state, mem_ready)});
      check("retired_w4", {28'd0, b_ret}, m_ret & 32'hf);
   endtask

   task automatic step(input bit rst, input logic [5:0] op, input bit mr);
      drive(rst, op, mr);
      check_model();
      tick();
   endtask

   task automatic add(input logic [5:0] op, input bit mr, input int st, input int ret);
      vec_t v;
      v.op = op; v.mr = mr; v.st = st; v.ret = ret;
      tbl.push_back(v);
   endtask

   localparam logic [5:0] X  = 6'h3f;  // filler outside DECODE; must be ignored
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000;

   initial begin
      logic [5:0] ops [6];
      ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BQ; ops[4] = JP; ops[5] = AD;

      // LW, R-type, BEQ, SW with MEM_WR waits, FETCH waits, ADDI, J
      add(X, 1, 0, 0); add(LW, 1, 1, 0); add(X, 1, 2, 0); add(X, 1, 3, 0);
      add(X, 1, 4, 0); add(X, 1, 0, 1);
      add(RT, 1, 1, 1); add(X, 1, 6, 1); add(X, 1, 7, 1); add(X, 1, 0, 2);
      add(BQ, 1, 1, 2); add(X, 1, 8, 2); add(X, 1, 0, 3);
      add(SW, 1, 1, 3); add(X, 1, 2, 3); add(X, 0, 5, 3); add(X, 0, 5, 3);
      add(X, 0, 5, 3); add(X, 1, 5, 3);
      add(X, 0, 0, 4); add(X, 0, 0, 4); add(X, 1, 0, 4);
      add(AD, 1, 1, 4); add(X, 1, 10, 4); add(X, 1, 11, 4); add(X, 1, 0, 5);
      add(JP, 1, 1, 5); add(X, 1, 9, 5); add(X, 1, 0, 6);

      drive(1, 6'd0, 1);
      tick();
      drive(1, 6'd0, 0);
      check("reset_state", {28'd0, a_state}, 32'd0);
      check("reset_ctrl", {15'd0, ctrl_a}, {15'd0, exp_ctrl(0, 0)});
      tick();

      foreach (tbl[i]) begin
         drive(0, tbl[i].op, tbl[i].mr);
         check($sformatf("tbl%0d_state", i), {28'd0, a_state}, tbl[i].st);
         check($sformatf("tbl%0d_retired", i), {16'd0, a_ret}, tbl[i].ret);
         check($sformatf("tbl%0d_ctrl", i), {15'd0, ctrl_a},
               {15'd0, exp_ctrl(tbl[i].st, tbl[i].mr)});
         tick();
      end

      // Illegal opcode traps until reset, whatever mem_ready does.
      step(1, 6'd0, 1);
      step(0, X, 1);
      step(0, 6'h3f, 1);
      for (int i = 0; i < 12; i++) begin
         drive(0, 6'($urandom), 1'($urandom));
         check("trap_halt", {31'd0, a_halt}, 32'd1);
         check("trap_state", {28'd0, a_state}, 32'd12);
         tick();
      end
      step(1, 6'd0, 1);
      drive(0, 6'd0, 0);
      check("post_trap_state", {28'd0, a_state}, 32'd0);
      check("post_trap_halt", {31'd0, a_halt}, 32'd0);
      check("post_trap_retired", {16'd0, a_ret}, 32'd0);
      tick();

      // 16 back-to-back jumps: the 4-bit counter wraps to 0.
      step(1, 6'd0, 1);
      for (int i = 0; i < 16; i++) begin
         step(0, X, 1);
         step(0, JP, 1);
         step(0, X, 1);
      end
      drive(0, X, 1);
      check("wrap_retired_w4", {28'd0, b_ret}, 32'd0);
      check("wrap_retired_w16", {16'd0, a_ret}, 32'd16);
      tick();

      // Reset while MEM_RD is waiting on memory.
      step(1, 6'd0, 1);
      step(0, X, 1);
      step(0, LW, 1);
      step(0, X, 1);
      step(0, X, 0);
      step(0, X, 0);
      step(1, X, 0);
      drive(0, X, 0);
      check("rd_wait_reset_state", {28'd0, a_state}, 32'd0);
      check("rd_wait_reset_ctrl", {15'd0, ctrl_a}, {15'd0, exp_ctrl(0, 0)});
      tick();

      // Randomized run against the instruction-level model.
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 39) == 0) op = 6'($urandom);
         step($urandom_range(0, 149) == 0, op, $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
